// File: rtl/cotm32_priv_pkg.sv
// Machine-mode privileged architecture definitions shared by the CSR/trap slice.
package cotm32_priv_pkg;

  localparam int XLEN  = 32;
  localparam int MXLEN = 32;

  typedef logic [MXLEN-1:0] trap_cause_t;

  typedef enum logic [1:0] {
    CSR_NONE = 2'd0,
    CSR_RW   = 2'd1,
    CSR_RS   = 2'd2,
    CSR_RC   = 2'd3
  } csr_op_t;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'd0,
    MTVEC_VECTORED = 2'd1
  } mtvec_mode_t;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIP_MTIP_BIT     = 7;

  // Read-modify-write result of a Zicsr operation
  function automatic logic [XLEN-1:0] csr_new_value(input csr_op_t op,
                                                    input logic [XLEN-1:0] old_val,
                                                    input logic [XLEN-1:0] wdata);
    case (op)
      CSR_RW:  return wdata;
      CSR_RS:  return old_val | wdata;
      CSR_RC:  return old_val & ~wdata;
      default: return old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// Trap/CSR bus between the core (master) and the CSR trap unit (slave).
interface csr_trap_unit_if;
  import cotm32_priv_pkg::*;

  logic            i_trap_req;
  trap_cause_t     i_trap_cause;
  logic [XLEN-1:0] i_trap_tval;
  logic [XLEN-1:0] i_pc;
  logic            i_retire;
  logic            i_mret;
  csr_op_t         i_csr_op;
  logic            i_csr_we;
  logic [11:0]     i_csr_addr;
  logic [XLEN-1:0] i_csr_wdata;
  logic            i_irq_mtimer;

  logic [XLEN-1:0] o_csr_rdata;
  logic            o_t_illegal_csr;
  logic [XLEN-1:0] o_trap_target;
  logic [XLEN-1:0] o_mret_target;
  logic            o_irq_req;
  logic            o_mie;

  modport master (
    output i_trap_req, i_trap_cause, i_trap_tval, i_pc, i_retire, i_mret,
           i_csr_op, i_csr_we, i_csr_addr, i_csr_wdata, i_irq_mtimer,
    input  o_csr_rdata, o_t_illegal_csr, o_trap_target, o_mret_target, o_irq_req, o_mie
  );

  modport slave (
    input  i_trap_req, i_trap_cause, i_trap_tval, i_pc, i_retire, i_mret,
           i_csr_op, i_csr_we, i_csr_addr, i_csr_wdata, i_irq_mtimer,
    output o_csr_rdata, o_t_illegal_csr, o_trap_target, o_mret_target, o_irq_req, o_mie
  );

endinterface

// File: rtl/csr_counter64.sv
// 64-bit event counter with separately writable halves.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [31:0] count_lo;
  logic [31:0] count_hi;

  // A write to either half freezes the other half for that cycle, so no carry can leak
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_lo <= '0;
      count_hi <= '0;
    end else if (we_lo || we_hi) begin
      if (we_lo) count_lo <= wdata;
      if (we_hi) count_hi <= wdata;
    end else if (inc) begin
      {count_hi, count_lo} <= {count_hi, count_lo} + 64'd1;
    end
  end

  assign count = {count_hi, count_lo};

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file, trap entry/mret sequencing and counters for the RV32 core.
module csr_trap_unit
  import cotm32_priv_pkg::*;
#(
  parameter logic [XLEN-1:0] HART_ID  = '0,
  parameter logic [XLEN-1:0] MISA_VAL = 32'h4000_0100
) (
  input logic            i_clk,
  input logic            i_rst,
  csr_trap_unit_if.slave bus
);

  logic            status_mie;
  logic            status_mpie;
  logic            mie_mtie;
  logic [XLEN-3:0] mtvec_base;
  mtvec_mode_t     mtvec_mode;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-3:0] mepc_word;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;
  logic [63:0]     mcycle;
  logic [63:0]     minstret;

  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] mie_val;
  logic [XLEN-1:0] mip_val;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic [XLEN-1:0] base_addr;
  logic [XLEN-1:0] trap_target;
  logic            implemented;
  logic            illegal;
  logic            trap;
  logic            mret;
  logic            csr_write;

  assign trap = bus.i_trap_req;
  assign mret = bus.i_mret & ~bus.i_trap_req;

  // Assemble architectural views of the sparsely implemented registers
  always_comb begin
    mstatus_val = '0;
    mstatus_val[MSTATUS_MIE_BIT]  = status_mie;
    mstatus_val[MSTATUS_MPIE_BIT] = status_mpie;
    mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mie_val = '0;
    mie_val[MIE_MTIE_BIT] = mie_mtie;
    mip_val = '0;
    mip_val[MIP_MTIP_BIT] = bus.i_irq_mtimer;
  end

  // Address decode: old value of the selected CSR and whether it exists
  always_comb begin
    implemented = 1'b1;
    old_val     = '0;
    case (bus.i_csr_addr)
      CSR_MSTATUS:   old_val = mstatus_val;
      CSR_MISA:      old_val = MISA_VAL;
      CSR_MIE:       old_val = mie_val;
      CSR_MTVEC:     old_val = {mtvec_base, mtvec_mode};
      CSR_MSCRATCH:  old_val = mscratch;
      CSR_MEPC:      old_val = {mepc_word, 2'b00};
      CSR_MCAUSE:    old_val = mcause;
      CSR_MTVAL:     old_val = mtval;
      CSR_MIP:       old_val = mip_val;
      CSR_MCYCLE:    old_val = mcycle[31:0];
      CSR_MCYCLEH:   old_val = mcycle[63:32];
      CSR_MINSTRET:  old_val = minstret[31:0];
      CSR_MINSTRETH: old_val = minstret[63:32];
      CSR_MHARTID:   old_val = HART_ID;
      default:       implemented = 1'b0;
    endcase
  end

  assign illegal = ((bus.i_csr_op != CSR_NONE) && !implemented) ||
                   (bus.i_csr_we && (bus.i_csr_addr[11:10] == 2'b11));
  assign new_val   = csr_new_value(bus.i_csr_op, old_val, bus.i_csr_wdata);
  assign csr_write = bus.i_csr_we && (bus.i_csr_op != CSR_NONE) && !illegal && !trap && !mret;

  assign bus.o_csr_rdata     = illegal ? '0 : old_val;
  assign bus.o_t_illegal_csr = illegal;

  // Handler address: vectored interrupts jump into the table, everything else to BASE
  always_comb begin
    base_addr   = {mtvec_base, 2'b00};
    trap_target = base_addr;
    if (mtvec_mode == MTVEC_VECTORED && bus.i_trap_cause[XLEN-1])
      trap_target = base_addr + {bus.i_trap_cause[XLEN-3:0], 2'b00};
  end

  assign bus.o_trap_target = trap_target;
  assign bus.o_mret_target = {mepc_word, 2'b00};
  assign bus.o_irq_req     = status_mie & mie_mtie & bus.i_irq_mtimer;
  assign bus.o_mie         = status_mie;

  // Interrupt-enable stack: trap pushes MIE into MPIE, mret pops it back
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      status_mie  <= 1'b0;
      status_mpie <= 1'b0;
    end else if (trap) begin
      status_mpie <= status_mie;
      status_mie  <= 1'b0;
    end else if (mret) begin
      status_mie  <= status_mpie;
      status_mpie <= 1'b1;
    end else if (csr_write && bus.i_csr_addr == CSR_MSTATUS) begin
      status_mie  <= new_val[MSTATUS_MIE_BIT];
      status_mpie <= new_val[MSTATUS_MPIE_BIT];
    end
  end

  // Trap state capture; software writes only land when no trap is being taken
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mepc_word <= '0;
      mcause    <= '0;
      mtval     <= '0;
    end else if (trap) begin
      mepc_word <= bus.i_pc[XLEN-1:2];
      mcause    <= bus.i_trap_cause;
      mtval     <= bus.i_trap_tval;
    end else begin
      if (csr_write && bus.i_csr_addr == CSR_MEPC)   mepc_word <= new_val[XLEN-1:2];
      if (csr_write && bus.i_csr_addr == CSR_MCAUSE) mcause    <= new_val;
      if (csr_write && bus.i_csr_addr == CSR_MTVAL)  mtval     <= new_val;
    end
  end

  // Plain software-owned registers; an unsupported mtvec mode keeps the old one
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mie_mtie   <= 1'b0;
      mtvec_base <= '0;
      mtvec_mode <= MTVEC_DIRECT;
      mscratch   <= '0;
    end else begin
      if (csr_write && bus.i_csr_addr == CSR_MIE) mie_mtie <= new_val[MIE_MTIE_BIT];
      if (csr_write && bus.i_csr_addr == CSR_MTVEC) begin
        mtvec_base <= new_val[XLEN-1:2];
        if (new_val[1:0] == MTVEC_DIRECT || new_val[1:0] == MTVEC_VECTORED)
          mtvec_mode <= mtvec_mode_t'(new_val[1:0]);
      end
      if (csr_write && bus.i_csr_addr == CSR_MSCRATCH) mscratch <= new_val;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (i_clk),
    .rst_n (i_rst),
    .inc   (1'b1),
    .we_lo (csr_write && bus.i_csr_addr == CSR_MCYCLE),
    .we_hi (csr_write && bus.i_csr_addr == CSR_MCYCLEH),
    .wdata (new_val),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (i_clk),
    .rst_n (i_rst),
    .inc   (bus.i_retire & ~trap),
    .we_lo (csr_write && bus.i_csr_addr == CSR_MINSTRET),
    .we_hi (csr_write && bus.i_csr_addr == CSR_MINSTRETH),
    .wdata (new_val),
    .count (minstret)
  );

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: reference model plus directed vectors.
module tb_csr_trap_unit;
  import cotm32_priv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  csr_trap_unit_if bus();

  csr_trap_unit #(
    .HART_ID  (32'h0),
    .MISA_VAL (32'h4000_0100)
  ) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state, kept as whole architectural values
  logic        m_mie, m_mpie, m_mtie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_mcycle, m_minstret;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_read(input logic [11:0] a, output logic [31:0] v);
    bit impl = 1'b1;
    v = 32'h0;
    case (a)
      12'h300: v = 32'h1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
      12'h301: v = 32'h4000_0100;
      12'h304: v = m_mtie ? 32'h80 : 32'h0;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = bus.i_irq_mtimer ? 32'h80 : 32'h0;
      12'hB00: v = m_mcycle[31:0];
      12'hB80: v = m_mcycle[63:32];
      12'hB02: v = m_minstret[31:0];
      12'hB82: v = m_minstret[63:32];
      12'hF14: v = 32'h0;
      default: impl = 1'b0;
    endcase
    return impl;
  endfunction

  function automatic bit model_illegal(input bit impl);
    return (bus.i_csr_op != CSR_NONE && !impl) || (bus.i_csr_we && bus.i_csr_addr >= 12'hC00);
  endfunction

  task automatic model_reset();
    m_mie = 1'b0; m_mpie = 1'b0; m_mtie = 1'b0;
    m_mtvec = 32'h0; m_mscratch = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0; m_mtval = 32'h0;
    m_mcycle = 64'h0; m_minstret = 64'h0;
  endtask

  task automatic model_step();
    logic [31:0] old, nv, wd;
    logic [63:0] cyc_n, ins_n;
    bit impl, wr;
    wd   = bus.i_csr_wdata;
    impl = model_read(bus.i_csr_addr, old);
    wr   = bus.i_csr_we && bus.i_csr_op != CSR_NONE && !model_illegal(impl) &&
           !bus.i_trap_req && !bus.i_mret;
    if (bus.i_csr_op == CSR_RW)      nv = wd;
    else if (bus.i_csr_op == CSR_RS) nv = old | wd;
    else                             nv = old & ~wd;
    cyc_n = m_mcycle + 64'd1;
    ins_n = m_minstret + ((bus.i_retire && !bus.i_trap_req) ? 64'd1 : 64'd0);
    if (wr) begin
      case (bus.i_csr_addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mtie = nv[7];
        12'h305: m_mtvec = {nv[31:2], (nv[1:0] <= 2'd1) ? nv[1:0] : m_mtvec[1:0]};
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & 32'hFFFF_FFFC;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'hB00: cyc_n = {m_mcycle[63:32], nv};
        12'hB80: cyc_n = {nv, m_mcycle[31:0]};
        12'hB02: ins_n = {m_minstret[63:32], nv};
        12'hB82: ins_n = {nv, m_minstret[31:0]};
        default: ;
      endcase
    end
    if (bus.i_trap_req) begin
      m_mepc = bus.i_pc & 32'hFFFF_FFFC;
      m_mcause = bus.i_trap_cause;
      m_mtval = bus.i_trap_tval;
      m_mpie = m_mie;
      m_mie = 1'b0;
    end else if (bus.i_mret) begin
      m_mie = m_mpie;
      m_mpie = 1'b1;
    end
    m_mcycle = cyc_n;
    m_minstret = ins_n;
  endtask

  // Advance the model at every clock edge; reset is asynchronous like the DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Compare every combinational output against the model, mid-cycle
  always @(negedge clk) begin : compare
    logic [31:0] old, base, exp_tt;
    bit impl, ill;
    impl = model_read(bus.i_csr_addr, old);
    ill  = model_illegal(impl);
    base = {m_mtvec[31:2], 2'b00};
    exp_tt = base;
    if (m_mtvec[1:0] == 2'b01 && bus.i_trap_cause[31])
      exp_tt = base + 32'(bus.i_trap_cause[30:0]) * 32'd4;
    check_output("rdata", bus.o_csr_rdata, ill ? 32'h0 : old);
    check_output("illegal", {31'b0, bus.o_t_illegal_csr}, {31'b0, ill});
    check_output("trap_target", bus.o_trap_target, exp_tt);
    check_output("mret_target", bus.o_mret_target, m_mepc);
    check_output("irq_req", {31'b0, bus.o_irq_req}, {31'b0, m_mie & m_mtie & bus.i_irq_mtimer});
    check_output("mie_out", {31'b0, bus.o_mie}, {31'b0, m_mie});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input csr_op_t op, input logic [11:0] a,
                                input logic [31:0] wd, input logic we);
    bus.i_csr_op = op;
    bus.i_csr_addr = a;
    bus.i_csr_wdata = wd;
    bus.i_csr_we = we;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] wd);
    apply_stimulus(CSR_RW, a, wd, 1'b1);
    step();
    apply_stimulus(CSR_NONE, 12'h000, 32'h0, 1'b0);
  endtask

  task automatic read_expect(input string name, input logic [11:0] a, input logic [31:0] exp);
    apply_stimulus(CSR_RS, a, 32'h0, 1'b0);
    #1;
    check_output(name, bus.o_csr_rdata, exp);
    apply_stimulus(CSR_NONE, 12'h000, 32'h0, 1'b0);
  endtask

  task automatic set_trap(input logic req, input logic [31:0] cause,
                          input logic [31:0] pc, input logic [31:0] tval);
    bus.i_trap_req = req;
    bus.i_trap_cause = cause;
    bus.i_pc = pc;
    bus.i_trap_tval = tval;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    set_trap(1'b0, 32'h0, 32'h0, 32'h0);
    bus.i_retire = 1'b0;
    bus.i_mret = 1'b0;
    bus.i_irq_mtimer = 1'b0;
    apply_stimulus(CSR_NONE, 12'h000, 32'h0, 1'b0);
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    $display("[TB] reset state");
    check_output("rst_trap_target", bus.o_trap_target, 32'h0);
    check_output("rst_mret_target", bus.o_mret_target, 32'h0);
    check_output("rst_irq", {31'b0, bus.o_irq_req}, 32'h0);
    check_output("rst_mie", {31'b0, bus.o_mie}, 32'h0);
    read_expect("rst_mscratch", 12'h340, 32'h0);
    #8 rst_n = 1'b1;

    repeat (5) step();
    read_expect("mcycle_5", 12'hB00, 32'd5);
    read_expect("minstret_0", 12'hB02, 32'd0);
    check_output("target_after_reset", bus.o_trap_target, 32'h0);

    $display("[TB] vectored interrupt entry");
    csr_write(12'h305, 32'h0000_0101);
    set_trap(1'b1, 32'h8000_0007, 32'h0000_0040, 32'h0);
    #1 check_output("vec_irq_target", bus.o_trap_target, 32'h0000_011C);
    step();
    set_trap(1'b0, 32'h0, 32'h0, 32'h0);
    read_expect("mepc_trap", 12'h341, 32'h0000_0040);
    read_expect("mcause_trap", 12'h342, 32'h8000_0007);
    read_expect("mstatus_trap", 12'h300, 32'h0000_1800);

    $display("[TB] MIE stack through trap and mret");
    apply_stimulus(CSR_RS, 12'h300, 32'h8, 1'b1);
    step();
    read_expect("mstatus_mie_set", 12'h300, 32'h0000_1808);
    csr_write(12'h304, 32'h80);
    bus.i_irq_mtimer = 1'b1;
    #1 check_output("irq_pending", {31'b0, bus.o_irq_req}, 32'h1);
    set_trap(1'b1, 32'h0000_0002, 32'h0000_0084, 32'h0000_DEAD);
    #1 check_output("vec_exc_target", bus.o_trap_target, 32'h0000_0100);
    step();
    set_trap(1'b0, 32'h0, 32'h0, 32'h0);
    read_expect("mstatus_in_trap", 12'h300, 32'h0000_1880);
    read_expect("mtval_trap", 12'h343, 32'h0000_DEAD);
    check_output("irq_masked", {31'b0, bus.o_irq_req}, 32'h0);
    bus.i_mret = 1'b1;
    step();
    bus.i_mret = 1'b0;
    read_expect("mstatus_mret", 12'h300, 32'h0000_1888);
    check_output("mret_target", bus.o_mret_target, 32'h0000_0084);
    check_output("mie_after_mret", {31'b0, bus.o_mie}, 32'h1);
    bus.i_irq_mtimer = 1'b0;

    $display("[TB] WARL fields");
    csr_write(12'h305, 32'h0000_0200);
    csr_write(12'h305, 32'h0000_0303);
    read_expect("mtvec_mode_kept", 12'h305, 32'h0000_0300);
    check_output("direct_target", bus.o_trap_target, 32'h0000_0300);
    csr_write(12'h341, 32'h0000_1003);
    read_expect("mepc_aligned", 12'h341, 32'h0000_1000);

    $display("[TB] illegal accesses");
    apply_stimulus(CSR_RW, 12'hF14, 32'h5, 1'b1);
    #1;
    check_output("hartid_wr_illegal", {31'b0, bus.o_t_illegal_csr}, 32'h1);
    check_output("hartid_wr_rdata", bus.o_csr_rdata, 32'h0);
    step();
    apply_stimulus(CSR_NONE, 12'h000, 32'h0, 1'b0);
    read_expect("hartid_unchanged", 12'hF14, 32'h0);
    apply_stimulus(CSR_RS, 12'h7C0, 32'h0, 1'b0);
    #1;
    check_output("unimpl_illegal", {31'b0, bus.o_t_illegal_csr}, 32'h1);
    check_output("unimpl_rdata", bus.o_csr_rdata, 32'h0);
    apply_stimulus(CSR_NONE, 12'h000, 32'h0, 1'b0);

    $display("[TB] counter carry");
    read_expect("mcycleh_0", 12'hB80, 32'h0);
    csr_write(12'hB00, 32'hFFFF_FFFF);
    read_expect("mcycle_preload", 12'hB00, 32'hFFFF_FFFF);
    read_expect("mcycleh_held", 12'hB80, 32'h0);
    step();
    read_expect("mcycle_wrap", 12'hB00, 32'h0);
    read_expect("mcycleh_carry", 12'hB80, 32'h1);

    $display("[TB] trap suppresses write and retire");
    csr_write(12'h340, 32'h0000_1234);
    bus.i_retire = 1'b1;
    repeat (3) step();
    bus.i_retire = 1'b0;
    read_expect("minstret_3", 12'hB02, 32'd3);
    bus.i_retire = 1'b1;
    set_trap(1'b1, 32'h0000_000B, 32'h0000_0200, 32'h0);
    apply_stimulus(CSR_RW, 12'h340, 32'h0000_BEEF, 1'b1);
    step();
    bus.i_retire = 1'b0;
    set_trap(1'b0, 32'h0, 32'h0, 32'h0);
    apply_stimulus(CSR_NONE, 12'h000, 32'h0, 1'b0);
    read_expect("mscratch_kept", 12'h340, 32'h0000_1234);
    read_expect("minstret_kept", 12'hB02, 32'd3);

    $display("[TB] trap beats mret");
    apply_stimulus(CSR_RS, 12'h300, 32'h8, 1'b1);
    step();
    apply_stimulus(CSR_NONE, 12'h000, 32'h0, 1'b0);
    set_trap(1'b1, 32'h0000_0003, 32'h0000_0300, 32'h0);
    bus.i_mret = 1'b1;
    step();
    bus.i_mret = 1'b0;
    set_trap(1'b0, 32'h0, 32'h0, 32'h0);
    read_expect("mstatus_trap_wins", 12'h300, 32'h0000_1880);

    $display("[TB] asynchronous reset mid-trap");
    set_trap(1'b1, 32'h8000_0007, 32'h0000_0500, 32'h0000_0011);
    rst_n = 1'b0;
    #1;
    read_expect("rst_mepc", 12'h341, 32'h0);
    check_output("rst_mid_target", bus.o_trap_target, 32'h0);
    set_trap(1'b0, 32'h0, 32'h0, 32'h0);
    #1 rst_n = 1'b1;
    step();
    read_expect("mcycle_after_rst", 12'hB00, 32'd1);
    read_expect("mcause_after_rst", 12'h342, 32'h0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
